// File: rtl/verisc_controller.sv
// VeriSC eight-phase sequencing controller: decodes phase, opcode and
// the accumulator-zero flag into datapath strobes, and counts retired instructions.
module verisc_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           opcode,
    input  logic                 zero,
    output logic                 sel,
    output logic                 rd,
    output logic                 ld_ir,
    output logic                 inc_pc,
    output logic                 ld_pc,
    output logic                 ld_ac,
    output logic                 wr,
    output logic                 data_e,
    output logic                 halt,
    output logic [2:0]           phase,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_e;

    phase_e               phase_q, phase_d;
    logic                 halted_q, halted_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic is_hlt, is_skz, is_sto, is_jmp, aluop;

    always_comb begin
        is_hlt = (opcode == OP_HLT);
        is_skz = (opcode == OP_SKZ);
        is_sto = (opcode == OP_STO);
        is_jmp = (opcode == OP_JMP);
        aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    // HLT freezes the sequencer in OP_ADDR; only reset releases it.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (!halted_q) begin
            if (phase_q == OP_ADDR && is_hlt) begin
                halted_d = 1'b1;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
                if (phase_q == STORE) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = halted_q;
        if (!halted_q) begin
            unique case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = is_skz && zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
            endcase
        end
    end

    assign phase       = phase_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_verisc_controller.sv
// Randomized bench for verisc_controller against a phase-rule reference model;
// a second instance with a 2-bit counter exercises counter wrap.
module tb_verisc_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  opcode;
    logic        zero;

    logic        sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0]  phase;
    logic [15:0] instr_count;

    logic        sel2, rd2, ld_ir2, inc_pc2, ld_pc2, ld_ac2, wr2, data_e2, halt2;
    logic [2:0]  phase2;
    logic [1:0]  instr_count2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    verisc_controller #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc),
        .ld_pc(ld_pc), .ld_ac(ld_ac), .wr(wr), .data_e(data_e),
        .halt(halt), .phase(phase), .instr_count(instr_count)
    );

    verisc_controller #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .sel(sel2), .rd(rd2), .ld_ir(ld_ir2), .inc_pc(inc_pc2),
        .ld_pc(ld_pc2), .ld_ac(ld_ac2), .wr(wr2), .data_e(data_e2),
        .halt(halt2), .phase(phase2), .instr_count(instr_count2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Strobe vector order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
    function automatic logic [8:0] expect_strobes(input int ph, input int op,
                                                  input bit z, input bit h);
        bit alu, s, r, li, ip, lp, la, w, de, hl;
        if (h) return 9'b0_0000_0001;
        alu = (op >= 2 && op <= 5);
        s   = (ph <= 3);
        r   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        li  = (ph == 2 || ph == 3);
        ip  = (ph == 4) || (ph == 6 && op == 1 && z);
        lp  = (ph >= 6 && op == 7);
        la  = (ph == 7 && alu);
        w   = (ph == 7 && op == 6);
        de  = (ph >= 6 && op == 6);
        hl  = (ph == 4 && op == 0);
        return {s, r, li, ip, lp, la, w, de, hl};
    endfunction

    int  m_ph;
    bit  m_halt;
    int  m_cnt;
    int  frozen;
    int  cur_op;

    initial begin
        rst    = 1'b1;
        opcode = 3'd0;
        zero   = 1'b0;
        m_ph   = 0;
        m_halt = 1'b0;
        m_cnt  = 0;
        frozen = 0;
        cur_op = 5;
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            // Pick a new instruction at each fetch; HLT is rare so programs run.
            if (m_ph == 0 && !m_halt) begin
                cur_op = ($urandom_range(0, 11) == 0) ? 0
                         : int'($urandom_range(1, 7));
            end
            opcode = 3'(cur_op);
            zero   = 1'($urandom_range(0, 1));
            if (m_halt) begin
                frozen++;
                rst = (frozen > 20 && $urandom_range(0, 3) == 0);
            end else begin
                rst = ($urandom_range(0, 59) == 0);
            end
            #1;
            check("strobes",
                  {23'd0, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt},
                  {23'd0, expect_strobes(m_ph, cur_op, zero, m_halt)});
            check("phase", {29'd0, phase}, 32'(m_ph));
            check("count16", {16'd0, instr_count}, 32'(m_cnt % 65536));
            check("count2", {30'd0, instr_count2}, 32'(m_cnt % 4));
            check("strobes2",
                  {23'd0, sel2, rd2, ld_ir2, inc_pc2, ld_pc2, ld_ac2, wr2, data_e2, halt2},
                  {23'd0, expect_strobes(m_ph, cur_op, zero, m_halt)});

            if (rst) begin
                m_ph   = 0;
                m_halt = 1'b0;
                m_cnt  = 0;
                frozen = 0;
            end else if (!m_halt) begin
                if (m_ph == 4 && cur_op == 0) begin
                    m_halt = 1'b1;
                end else begin
                    if (m_ph == 7) m_cnt++;
                    m_ph = (m_ph + 1) % 8;
                end
            end
            @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
